// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - PRESENT cipher constants, S-box table, pLayer and FSM state type
package present_pkg;

  localparam int MAX_ROUNDS = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  // Bit i moves to i*16 mod 63; bit 63 stays in place.
  function automatic logic [63:0] p_layer(input logic [63:0] din);
    logic [63:0] dout;
    dout = '0;
    for (int i = 0; i < 63; i++) begin
      dout[(i * 16) % 63] = din[i];
    end
    dout[63] = din[63];
    return dout;
  endfunction

endpackage

// File: rtl/present_sbox4.sv
// rtl/present_sbox4.sv - 4-bit combinational PRESENT S-box
module present_sbox4
  import present_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = SBOX[din];

endmodule

// File: rtl/present_encrypt_core.sv
// rtl/present_encrypt_core.sv - iterative PRESENT-80/128 encryption core, one round per clock
// Optional PRESENT_ROUNDKEY_OUT_EN adds out_rkey (key register captured at the final key-add).
module present_encrypt_core
  import present_pkg::*;
#(
  parameter int KEY_WIDTH  = 80,
  parameter int NUM_ROUNDS = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_data,
  input  logic [KEY_WIDTH-1:0] in_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic                 busy
`ifdef PRESENT_ROUNDKEY_OUT_EN
  ,
  output logic [KEY_WIDTH-1:0] out_rkey
`endif
);

  generate
    if ((KEY_WIDTH != 80 && KEY_WIDTH != 128) || NUM_ROUNDS < 1 || NUM_ROUNDS > MAX_ROUNDS) begin : g_bad_cfg
      $error("present_encrypt_core: KEY_WIDTH must be 80 or 128 and NUM_ROUNDS 1..31");
    end
  endgenerate

  // The final key-add happens at round NUM_ROUNDS+1; for 31 rounds that is 32,
  // which the 5-bit counter sees as 0 after its last increment.
  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS + 1);

  state_e                 state_q, state_d;
  logic [63:0]            data_q, data_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [4:0]             round_q, round_d;
  logic [63:0]            out_data_q, out_data_d;

  logic [63:0]            round_key;
  logic [63:0]            sbox_in;
  logic [63:0]            sbox_out;
  logic [63:0]            perm_out;
  logic [KEY_WIDTH-1:0]   key_rot;
  logic [KEY_WIDTH-1:0]   key_sched;
  logic [3:0]             ks_hi;

  assign round_key = key_q[KEY_WIDTH-1 -: 64];
  assign sbox_in   = data_q ^ round_key;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    present_sbox4 u_sbox (
      .din  (sbox_in[4*i +: 4]),
      .dout (sbox_out[4*i +: 4])
    );
  end

  assign perm_out = p_layer(sbox_out);

  assign key_rot = {key_q[KEY_WIDTH-62:0], key_q[KEY_WIDTH-1:KEY_WIDTH-61]};

  present_sbox4 u_ks_hi (
    .din  (key_rot[KEY_WIDTH-1 -: 4]),
    .dout (ks_hi)
  );

  generate
    if (KEY_WIDTH == 128) begin : g_k128
      logic [3:0] ks_lo;
      present_sbox4 u_ks_lo (
        .din  (key_rot[123:120]),
        .dout (ks_lo)
      );
      always_comb begin
        key_sched          = key_rot;
        key_sched[127:124] = ks_hi;
        key_sched[123:120] = ks_lo;
        key_sched[66:62]   = key_rot[66:62] ^ round_q;
      end
    end else begin : g_k80
      always_comb begin
        key_sched        = key_rot;
        key_sched[79:76] = ks_hi;
        key_sched[19:15] = key_rot[19:15] ^ round_q;
      end
    end
  endgenerate

`ifdef PRESENT_ROUNDKEY_OUT_EN
  logic [KEY_WIDTH-1:0] out_rkey_q, out_rkey_d;
`endif

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    key_d      = key_q;
    round_d    = round_q;
    out_data_d = out_data_q;
`ifdef PRESENT_ROUNDKEY_OUT_EN
    out_rkey_d = out_rkey_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          key_d   = in_key;
          round_d = 5'd1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (round_q == LAST_ROUND) begin
          out_data_d = data_q ^ round_key;
`ifdef PRESENT_ROUNDKEY_OUT_EN
          out_rkey_d = key_q;
`endif
          state_d    = ST_DONE;
        end else begin
          data_d  = perm_out;
          key_d   = key_sched;
          round_d = round_q + 5'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      key_q      <= '0;
      round_q    <= '0;
      out_data_q <= '0;
`ifdef PRESENT_ROUNDKEY_OUT_EN
      out_rkey_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      key_q      <= key_d;
      round_q    <= round_d;
      out_data_q <= out_data_d;
`ifdef PRESENT_ROUNDKEY_OUT_EN
      out_rkey_q <= out_rkey_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign out_data  = out_data_q;
`ifdef PRESENT_ROUNDKEY_OUT_EN
  assign out_rkey  = out_rkey_q;
`endif

endmodule

// File: tb/tb_present_encrypt_core.sv
// tb/tb_present_encrypt_core.sv - randomized bench for PRESENT-80, PRESENT-128 and a 1-round build
module tb_present_encrypt_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  busy;
  logic [63:0]  in_data  [3];
  logic [127:0] in_key   [3];
  logic [63:0]  out_data [3];
`ifdef PRESENT_ROUNDKEY_OUT_EN
  logic [79:0]  rk0;
  logic [127:0] rk1;
  logic [79:0]  rk2;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  present_encrypt_core #(.KEY_WIDTH(80), .NUM_ROUNDS(31)) u_dut80 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_key(in_key[0][79:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
`ifdef PRESENT_ROUNDKEY_OUT_EN
    , .out_rkey(rk0)
`endif
  );

  present_encrypt_core #(.KEY_WIDTH(128), .NUM_ROUNDS(31)) u_dut128 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_key(in_key[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
`ifdef PRESENT_ROUNDKEY_OUT_EN
    , .out_rkey(rk1)
`endif
  );

  present_encrypt_core #(.KEY_WIDTH(80), .NUM_ROUNDS(1)) u_dut1r (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_key(in_key[2][79:0]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2])
`ifdef PRESENT_ROUNDKEY_OUT_EN
    , .out_rkey(rk2)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h2174_8FE3_DA09_B65C;
    return tbl[x*4 +: 4];
  endfunction

  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [127:0] key,
                                          input int kw, input int nr, output logic [127:0] fkey);
    logic [63:0]  s, t;
    logic [79:0]  k80;
    logic [127:0] k128;
    logic [63:0]  rk;
    s    = pt;
    k80  = key[79:0];
    k128 = key;
    for (int r = 1; r <= nr; r++) begin
      rk = (kw == 80) ? k80[79:16] : k128[127:64];
      s  = s ^ rk;
      for (int n = 0; n < 16; n++) s[n*4 +: 4] = ref_sbox(s[n*4 +: 4]);
      t = '0;
      for (int b = 0; b < 64; b++) t[16*(b%4) + b/4] = s[b];
      s = t;
      if (kw == 80) begin
        k80 = (k80 << 61) | (k80 >> 19);
        k80[79:76] = ref_sbox(k80[79:76]);
        k80[19:15] = k80[19:15] ^ 5'(r);
      end else begin
        k128 = (k128 << 61) | (k128 >> 67);
        k128[127:124] = ref_sbox(k128[127:124]);
        k128[123:120] = ref_sbox(k128[123:120]);
        k128[66:62]   = k128[66:62] ^ 5'(r);
      end
    end
    rk   = (kw == 80) ? k80[79:16] : k128[127:64];
    fkey = (kw == 80) ? {48'b0, k80} : k128;
    return s ^ rk;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(input int d, input logic [63:0] pt, input logic [127:0] key,
                           input logic [63:0] known, input bit use_known, input int stall,
                           input string tag);
    int           kw, nr, n;
    logic [63:0]  exp;
    logic [127:0] fkey;
    logic [127:0] kmask;
    bit           ok;
    kw    = (d == 1) ? 128 : 80;
    nr    = (d == 2) ? 1 : 31;
    kmask = (kw == 80) ? {48'b0, {80{1'b1}}} : {128{1'b1}};
    exp   = ref_enc(pt, key & kmask, kw, nr, fkey);
    if (use_known) exp = known;
    @(negedge clk);
    check({tag, ".in_ready"}, 128'(in_ready[d]), 128'd1);
    in_valid[d]  = 1'b1;
    in_data[d]   = pt;
    in_key[d]    = key & kmask;
    out_ready[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_data[d] = {$urandom, $urandom};
    in_key[d]  = rnd128() & kmask;
    check({tag, ".busy"}, {125'b0, busy[d], in_ready[d], out_valid[d]}, 128'b100);
    n = 0;
    while (!out_valid[d] && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, ".latency"}, 128'(n), 128'(nr + 1));
    check({tag, ".data"}, {64'b0, out_data[d]}, {64'b0, exp});
`ifdef PRESENT_ROUNDKEY_OUT_EN
    case (d)
      0:       check({tag, ".rkey"}, {48'b0, rk0}, fkey);
      1:       check({tag, ".rkey"}, rk1, fkey);
      default: check({tag, ".rkey"}, {48'b0, rk2}, fkey);
    endcase
`endif
    if (stall > 0) begin
      ok = 1'b1;
      repeat (stall) begin
        @(posedge clk);
        @(negedge clk);
        if (out_data[d] !== exp || out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || busy[d] !== 1'b0)
          ok = 1'b0;
      end
      check({tag, ".stall_hold"}, 128'(ok), 128'd1);
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
    check({tag, ".post_hs"}, {126'b0, out_valid[d], in_ready[d]}, 128'b01);
  endtask

  initial begin
    bit never;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 3; i++) begin
      in_data[i] = '0;
      in_key[i]  = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset%0d.flags", i), {125'b0, in_ready[i], out_valid[i], busy[i]}, 128'b100);
      check($sformatf("reset%0d.data", i), {64'b0, out_data[i]}, 128'd0);
    end
    rst_n = 1'b1;

    run_block(0, 64'h0, 128'h0, 64'h5579c1387b228445, 1'b1, 0, "k80_zero");
    run_block(0, 64'h0, {48'b0, {80{1'b1}}}, 64'he72c46c0f5945049, 1'b1, 0, "k80_keyones");
    run_block(0, {64{1'b1}}, 128'h0, 64'ha112ffc72f68417b, 1'b1, 10, "k80_ptones");
    run_block(0, {64{1'b1}}, {48'b0, {80{1'b1}}}, 64'h3333dcd3213210d2, 1'b1, 0, "k80_ones");
    run_block(1, 64'h0, 128'h0, 64'h96db702a2e6900af, 1'b1, 3, "k128_zero");

    for (int v = 0; v < 6; v++) begin
      run_block(0, {$urandom, $urandom}, rnd128(), 64'h0, 1'b0, int'($urandom_range(0, 3)),
                $sformatf("k80_rand%0d", v));
      run_block(1, {$urandom, $urandom}, rnd128(), 64'h0, 1'b0, int'($urandom_range(0, 3)),
                $sformatf("k128_rand%0d", v));
      run_block(2, {$urandom, $urandom}, rnd128(), 64'h0, 1'b0, int'($urandom_range(0, 3)),
                $sformatf("r1_rand%0d", v));
    end

    // Abort a block mid-run with reset and make sure it never produces output.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = {$urandom, $urandom};
    in_key[0]   = {48'b0, rnd128() & {48'b0, {80{1'b1}}}};
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort.flags", {125'b0, in_ready[0], out_valid[0], busy[0]}, 128'b100);
    check("abort.data", {64'b0, out_data[0]}, 128'd0);
    rst_n = 1'b1;
    never = 1'b1;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid[0] !== 1'b0) never = 1'b0;
    end
    check("abort.no_output", 128'(never), 128'd1);
    run_block(0, 64'h0, 128'h0, 64'h5579c1387b228445, 1'b1, 0, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
